serial_xs3_bcd_converter: RTL and testbench

- Bit-serial, LSB-first code converter for multi-digit words. Runtime-selectable direction: Excess-3 to BCD (subtract 3 per digit) or BCD to Excess-3 (add 3 per digit).
- Mealy output: each Z bit is produced in the same cycle as its X bit.
- Adds input-valid gating, digit/word framing, per-digit invalid-code detection and a per-word error summary.
- Parametrised successor of the fixed 4-bit single-digit converter. Sits between the serial pin interface and the digit-collection logic.

---
 rtl/serial_xs3_bcd_converter_pkg.sv | 26 ++
 rtl/serial_xs3_bcd_converter_if.sv | 26 ++
 rtl/serial_xs3_bcd_converter_alu.sv | 48 ++++
 rtl/serial_xs3_bcd_converter.sv | 90 +++++++++
 tb/tb_serial_xs3_bcd_converter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serial_xs3_bcd_converter_pkg.sv
// Shared definitions for the serial Excess-3 / BCD converter: mode
// encodings, the per-digit constant and the digit validity rule.
package serial_code_pkg;

  typedef enum logic {
    MODE_XS3_TO_BCD = 1'b0,
    MODE_BCD_TO_XS3 = 1'b1
  } mode_e;

  // Constant added or subtracted per digit, consumed LSB-first.
  localparam logic [3:0] K = 4'b0011;

  // Legal input code ranges for each direction.
  localparam logic [3:0] XS3_MIN = 4'd3;
  localparam logic [3:0] XS3_MAX = 4'd12;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when a complete 4-bit input code is legal for the given direction.
  function automatic logic code_valid(input mode_e mode, input logic [3:0] code);
    if (mode == MODE_XS3_TO_BCD) begin
      return (code >= XS3_MIN) && (code <= XS3_MAX);
    end
    return code <= BCD_MAX;
  endfunction

endpackage

// File: rtl/serial_xs3_bcd_converter_if.sv
// Serial pin-side bundle of the converter. The master drives the bit
// stream and mode; the slave (the converter) returns converted bits and
// framing/error strobes.
interface serial_xs3_bcd_converter_if;

  logic X;
  logic X_valid;
  logic Mode;
  logic Z;
  logic Z_valid;
  logic Digit_end;
  logic Digit_err;
  logic Word_done;
  logic Word_err;

  modport master (
    output X, X_valid, Mode,
    input  Z, Z_valid, Digit_end, Digit_err, Word_done, Word_err
  );

  modport slave (
    input  X, X_valid, Mode,
    output Z, Z_valid, Digit_end, Digit_err, Word_done, Word_err
  );

endinterface

// File: rtl/serial_xs3_bcd_converter_alu.sv
// Bit-serial add/subtract of the constant K for one digit. Holds the
// carry/borrow and the last three input bits so the complete code can be
// checked for legality on the digit's final bit.
module serial_digit_alu
  import serial_code_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       x_i,
  input  logic       accept_i,
  input  logic [1:0] bit_pos_i,
  input  mode_e      mode_i,
  output logic       z_o,
  output logic       digit_ok_o
);

  logic       cb_q;
  logic       cb_d;
  logic [2:0] sh_q;
  logic       k;

  // Sum/difference bit, next carry/borrow and digit legality.
  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    k          = K[bit_pos_i];
    z_o        = x_i ^ k ^ cb_q;
    cb_d       = 1'b0;
    if (mode_i == MODE_XS3_TO_BCD) begin
      cb_d = (~x_i & (k | cb_q)) | (k & cb_q);
    end else begin
      cb_d = (x_i & k) | (cb_q & (x_i ^ k));
    end
    digit_ok_o = code_valid(mode_i, {x_i, sh_q});
  end

  // Carry/borrow and input history advance on accepted bits; carry never crosses a digit.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cb_q <= 1'b0;
      sh_q <= 3'b000;
    end else if (accept_i) begin
      cb_q <= (bit_pos_i == 2'd3) ? 1'b0 : cb_d;
      sh_q <= {x_i, sh_q[2:1]};
    end
  end

endmodule

// File: rtl/serial_xs3_bcd_converter.sv
// Multi-digit serial Excess-3 <-> BCD converter. Frames the bit stream
// into digits and words, latches the direction at the start of each word
// and summarises per-digit errors into a per-word error flag.
module serial_xs3_bcd_converter
  import serial_code_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input logic                       Clk,
  input logic                       Rst,
  serial_xs3_bcd_converter_if.slave bus
);

  logic [1:0]       bit_pos_q;
  logic [CNT_W-1:0] digit_cnt_q;
  mode_e            mode_q;
  logic             err_acc_q;
  logic             word_done_q;
  logic             word_err_q;

  logic             word_start;
  mode_e            active_mode;
  logic             digit_end;
  logic             digit_err;
  logic             last_digit;
  logic             z_raw;
  logic             digit_ok;

  // Direction comes straight from the pin on a word's first bit, else from the latch.
  always_comb begin
    word_start  = (bit_pos_q == 2'd0) && (digit_cnt_q == '0);
    active_mode = word_start ? mode_e'(bus.Mode) : mode_q;
    digit_end   = bus.X_valid && (bit_pos_q == 2'd3);
    digit_err   = digit_end && !digit_ok;
    last_digit  = (digit_cnt_q == CNT_W'(DIGITS - 1));
  end

  serial_digit_alu u_alu (
    .Clk        (Clk),
    .Rst        (Rst),
    .x_i        (bus.X),
    .accept_i   (bus.X_valid),
    .bit_pos_i  (bit_pos_q),
    .mode_i     (active_mode),
    .z_o        (z_raw),
    .digit_ok_o (digit_ok)
  );

  // Framing, mode latch, error accumulation and the registered word strobes.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bit_pos_q   <= 2'd0;
      digit_cnt_q <= '0;
      mode_q      <= MODE_XS3_TO_BCD;
      err_acc_q   <= 1'b0;
      word_done_q <= 1'b0;
      word_err_q  <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      if (bus.X_valid) begin
        bit_pos_q <= bit_pos_q + 2'd1;
        if (word_start) begin
          mode_q <= mode_e'(bus.Mode);
        end
        if (digit_err) begin
          err_acc_q <= 1'b1;
        end
        if (digit_end) begin
          if (last_digit) begin
            digit_cnt_q <= '0;
            word_done_q <= 1'b1;
            word_err_q  <= err_acc_q | digit_err;
            err_acc_q   <= 1'b0;
          end else begin
            digit_cnt_q <= digit_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.Z         = bus.X_valid & z_raw;
  assign bus.Z_valid   = bus.X_valid;
  assign bus.Digit_end = digit_end;
  assign bus.Digit_err = digit_err;
  assign bus.Word_done = word_done_q;
  assign bus.Word_err  = word_err_q;

endmodule

// File: tb/tb_serial_xs3_bcd_converter.sv
// Directed bench for serial_xs3_bcd_converter (DIGITS = 4). Each digit is
// sent LSB-first; the Mealy outputs are sampled mid-cycle and the
// registered word strobes just after the clock edge.
module tb_serial_xs3_bcd_converter;

  logic Clk;
  logic Rst;
  int   passed;
  int   total;

  serial_xs3_bcd_converter_if bus ();

  serial_xs3_bcd_converter #(.DIGITS(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Sends one digit. m0 drives Mode on bit 0, m123 on bits 1..3.
  // Starts and ends 1 time unit after a rising edge.
  task automatic send_digit(input string tag, input logic [3:0] code, input logic m0,
                            input logic m123, input logic [3:0] exp_z, input logic exp_err,
                            input logic last, input logic exp_werr, input logic gaps);
    logic [3:0] z;
    logic       derr;
    z    = 4'h0;
    derr = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 99) < 30) begin
          bus.X_valid = 1'b0;
          bus.X       = 1'($urandom);
          #2;
          check({tag, " gap Digit_end"}, bus.Digit_end, 1'b0);
          check({tag, " gap Digit_err"}, bus.Digit_err, 1'b0);
          check({tag, " gap Z_valid"}, bus.Z_valid, 1'b0);
          @(posedge Clk);
          #1;
          check({tag, " gap Word_done"}, bus.Word_done, 1'b0);
        end
      end
      bus.X_valid = 1'b1;
      bus.X       = code[b];
      bus.Mode    = (b == 0) ? m0 : m123;
      #2;
      z[b] = bus.Z;
      if (b == 3) derr = bus.Digit_err;
      check({tag, " Digit_end"}, bus.Digit_end, (b == 3));
      @(posedge Clk);
      #1;
      check({tag, " Word_done"}, bus.Word_done, (b == 3) && last);
    end
    check({tag, " Z"}, z, exp_z);
    check({tag, " Digit_err"}, derr, exp_err);
    if (last) check({tag, " Word_err"}, bus.Word_err, exp_werr);
  endtask

  task automatic idle(input int n);
    bus.X_valid = 1'b0;
    bus.X       = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      check("idle Word_done", bus.Word_done, 1'b0);
    end
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    Rst         = 1'b0;
    bus.X       = 1'b0;
    bus.X_valid = 1'b0;
    bus.Mode    = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset Word_done", bus.Word_done, 1'b0);
    check("reset Word_err", bus.Word_err, 1'b0);
    check("reset Digit_end", bus.Digit_end, 1'b0);
    check("reset Z_valid", bus.Z_valid, 1'b0);
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    // XS3 -> BCD clean word: 8,4,12,3 -> 5,1,9,0
    send_digit("w1 d0", 4'd8,  1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w1 d1", 4'd4,  1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w1 d2", 4'd12, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w1 d3", 4'd3,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // BCD -> XS3 word: 7,9,5,3 -> 10,12,8,6 (Word_done directly followed by next word)
    send_digit("w2 d0", 4'd7, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w2 d1", 4'd9, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w2 d2", 4'd5, 1'b1, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w2 d3", 4'd3, 1'b1, 1'b1, 4'd6,  1'b0, 1'b1, 1'b0, 1'b0);

    // XS3 -> BCD with invalid codes 1 and 15: 6,1,15,10 -> 3,14,12,7
    send_digit("w3 d0", 4'd6,  1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w3 d1", 4'd1,  1'b0, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    send_digit("w3 d2", 4'd15, 1'b0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    send_digit("w3 d3", 4'd10, 1'b0, 1'b0, 4'd7,  1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // XS3 range edges: 3,12 legal; 2,13 illegal -> 0,9,15,10
    send_digit("w4 d0", 4'd3,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w4 d1", 4'd12, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w4 d2", 4'd2,  1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    send_digit("w4 d3", 4'd13, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0);

    // BCD range edge: 9 legal, 10 illegal (->13); only the first digit is bad
    send_digit("w5 d0", 4'd10, 1'b1, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    send_digit("w5 d1", 4'd9,  1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w5 d2", 4'd0,  1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w5 d3", 4'd1,  1'b1, 1'b1, 4'd4,  1'b0, 1'b1, 1'b1, 1'b0);

    // Error accumulator must be clear for the next clean word, sent with random gaps
    send_digit("w6 d0", 4'd8,  1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_digit("w6 d1", 4'd4,  1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_digit("w6 d2", 4'd12, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    send_digit("w6 d3", 4'd3,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset after bit 2 of digit 1 of a BCD->XS3 word
    send_digit("w7 d0", 4'd7, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      bus.X_valid = 1'b1;
      bus.X       = 1'b1;
      bus.Mode    = 1'b1;
      @(posedge Clk);
      #1;
      check("w7 partial Word_done", bus.Word_done, 1'b0);
    end
    bus.X_valid = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    check("mid reset Word_done", bus.Word_done, 1'b0);
    check("mid reset Digit_end", bus.Digit_end, 1'b0);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("post reset Word_done", bus.Word_done, 1'b0);

    // Fresh word with Mode re-latched to XS3 -> BCD
    send_digit("w8 d0", 4'd8,  1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w8 d1", 4'd4,  1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w8 d2", 4'd12, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w8 d3", 4'd3,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Mode flipped to 1 at bit 1 of digit 2: the word stays XS3 -> BCD
    send_digit("w9 d0", 4'd8,  1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w9 d1", 4'd4,  1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w9 d2", 4'd12, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w9 d3", 4'd3,  1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Next word picks up BCD -> XS3: 0,9,5,3 -> 3,12,8,6
    send_digit("w10 d0", 4'd0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w10 d1", 4'd9, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w10 d2", 4'd5, 1'b1, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0);
    send_digit("w10 d3", 4'd3, 1'b1, 1'b1, 4'd6,  1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
